// File: rtl/ram512_arb_pkg.sv
// Shared definitions for the RAM512 two-port arbiter: FSM state encoding,
// port identifiers and default data/address widths.
package ram512_arb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 9;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way request picker for the RAM512 arbiter.
// Default: round-robin, where the port that did not win last time takes a tie.
// With RAM512_ARB_FIXED_PRIO_EN defined, port 0 always wins a tie and the
// last-grant input is ignored, so port 1 can starve under constant contention.
module rr_pick2
  import ram512_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_lastGrant,
  output logic       o_grantId,
  output logic       o_anyReq
);

`ifdef RAM512_ARB_FIXED_PRIO_EN
  logic w_unusedLastGrant;
  assign w_unusedLastGrant = i_lastGrant;
`endif

  // Winner selection; port 0 is the fallback whenever it is the only option
  always_comb begin
    o_anyReq  = |i_req;
    o_grantId = PORT0;
`ifdef RAM512_ARB_FIXED_PRIO_EN
    if (!i_req[0] && i_req[1]) begin
      o_grantId = PORT1;
    end
`else
    if (&i_req) begin
      o_grantId = ~i_lastGrant;
    end else if (i_req[1]) begin
      o_grantId = PORT1;
    end
`endif
  end

endmodule

// File: rtl/ram512_arbiter.sv
// Two-port arbiter sharing one external RAM512 between two req/ack requesters.
// A winning command is latched in IDLE, driven onto the RAM for exactly one
// ACCESS cycle, and acknowledged with registered read data in RESP.
// Optional build macro: RAM512_ARB_FIXED_PRIO_EN (fixed priority to port 0
// instead of round-robin), handled inside rr_pick2.
module ram512_arbiter
  import ram512_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [DATA_W-1:0] ram_out
);

  state_t            r_state;
  state_t            w_nextState;
  logic [ADDR_W-1:0] r_addrQ;
  logic [DATA_W-1:0] r_wdataQ;
  logic [DATA_W-1:0] r_rdata;
  logic              r_weQ;
  logic              r_idQ;
  logic              r_lastGrant;
  logic              w_grantId;
  logic              w_anyReq;
  logic              w_take;

  rr_pick2 u_pick (
    .i_req       (req),
    .i_lastGrant (r_lastGrant),
    .o_grantId   (w_grantId),
    .o_anyReq    (w_anyReq)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and per-state outputs; ram_load is masked by reset so an
  // ACCESS cycle interrupted by reset never writes the RAM
  always_comb begin
    w_nextState = r_state;
    ack         = 2'b00;
    busy        = 1'b0;
    ram_load    = 1'b0;
    w_take      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_anyReq) begin
          w_take      = 1'b1;
          w_nextState = ACCESS;
        end
      end
      ACCESS: begin
        busy        = 1'b1;
        ram_load    = r_weQ & ~reset;
        w_nextState = RESP;
      end
      RESP: begin
        busy        = 1'b1;
        ack[r_idQ]  = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Command latch: capture the winner's request and remember who won,
  // last grant starts at port 1 so port 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idQ       <= PORT0;
      r_weQ       <= 1'b0;
      r_addrQ     <= '0;
      r_wdataQ    <= '0;
      r_lastGrant <= PORT1;
    end else if (w_take) begin
      r_idQ       <= w_grantId;
      r_weQ       <= we[w_grantId];
      r_addrQ     <= w_grantId ? addr1 : addr0;
      r_wdataQ    <= w_grantId ? wdata1 : wdata0;
      r_lastGrant <= w_grantId;
    end
  end

  // Response data: reads return the RAM output, writes echo the written data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (r_state == ACCESS) begin
      r_rdata <= r_weQ ? r_wdataQ : ram_out;
    end
  end

  assign rdata       = r_rdata;
  assign ram_address = r_addrQ;
  assign ram_in      = r_wdataQ;

endmodule

// File: tb/tb_ram512_arbiter.sv
// Self-checking bench for ram512_arbiter with a behavioural RAM512 attached.
// Honours RAM512_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_ram512_arbiter;

  localparam int DW = 16;
  localparam int AW = 9;

`ifdef RAM512_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic [DW-1:0] ram_in;
  logic          ram_load;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_out;
  logic          memClear;
  logic [DW-1:0] mem [0:511];

  int testsRun   = 0;
  int failures   = 0;
  int cycleCount = 0;

  typedef struct {
    logic [1:0]    ack;
    logic [DW-1:0] rdata;
    int            cyc;
  } expT;
  expT sbQ[$];

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] expRdata;
  } vecT;
  vecT vecs[7];

  logic [AW-1:0] bbAddr[4];
  logic [DW-1:0] bbData[4];

  ram512_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         ({req1, req0}),
    .we          ({we1, we0}),
    .addr0       (addr0),
    .addr1       (addr1),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack         (ack),
    .rdata       (rdata),
    .busy        (busy),
    .ram_in      (ram_in),
    .ram_load    (ram_load),
    .ram_address (ram_address),
    .ram_out     (ram_out)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Free-running cycle counter for spacing checks
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Behavioural RAM512: write on clock edge, combinational read
  always @(posedge clk) begin
    if (memClear) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
    end else if (ram_load) begin
      mem[ram_address] <= ram_in;
    end
  end
  assign ram_out = mem[ram_address];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int p, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [DW-1:0] expR);
    expT e;
    if (p == 0) begin
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    e.ack   = (p == 0) ? 2'b01 : 2'b10;
    e.rdata = expR;
    e.cyc   = -1;
    sbQ.push_back(e);
  endtask

  task automatic popAndCheck(input int relCyc);
    expT e;
    if (sbQ.size() == 0) begin
      checkOutput("unexpected_ack", 32'(ack), 32'd0);
    end else begin
      e = sbQ.pop_front();
      checkOutput("ack_port", 32'(ack), 32'(e.ack));
      checkOutput("rdata", 32'(rdata), 32'(e.rdata));
      if (e.cyc >= 0) checkOutput("ack_cycle", 32'(relCyc), 32'(e.cyc));
    end
  endtask

  task automatic waitAck(output int lat, output int loads, output int busyCyc,
                         output logic [AW-1:0] loadAddr);
    lat = 0; loads = 0; busyCyc = 0; loadAddr = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      lat++;
      if (busy) busyCyc++;
      if (ram_load) begin
        loads++;
        loadAddr = ram_address;
      end
      if (ack != 2'b00) begin
        popAndCheck(-1);
        if (ack[0]) req0 = 1'b0;
        if (ack[1]) req1 = 1'b0;
        return;
      end
    end
    checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Watchdog so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence
  initial begin
    int lat, loads, bc, prevCyc, startCyc, p0Acks, p1Acks;
    logic [AW-1:0] la;
    expT e;

    vecs = '{
      '{0, 1'b1, 9'd8,   16'h2008, 16'h2008},
      '{1, 1'b0, 9'd8,   16'h0000, 16'h2008},
      '{1, 1'b1, 9'd100, 16'h1234, 16'h1234},
      '{0, 1'b0, 9'd100, 16'h0000, 16'h1234},
      '{0, 1'b1, 9'd511, 16'hABCD, 16'hABCD},
      '{1, 1'b0, 9'd511, 16'h0000, 16'hABCD},
      '{1, 1'b0, 9'd0,   16'h0000, 16'h0000}
    };
    bbAddr = '{9'd0, 9'd1, 9'd163, 9'd263};
    bbData = '{16'h5000, 16'h5001, 16'h5163, 16'h5263};

    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    memClear = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    memClear = 1'b0;
    reset = 1'b0;

    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_rdata", 32'(rdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ram_load", 32'(ram_load), 32'd0);
    checkOutput("rst_ram_address", 32'(ram_address), 32'd0);
    checkOutput("rst_ram_in", 32'(ram_in), 32'd0);

    // Single transactions from idle
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expRdata);
      waitAck(lat, loads, bc, la);
      checkOutput("latency", 32'(lat), 32'd2);
      checkOutput("load_count", 32'(loads), 32'(vecs[i].we));
      if (vecs[i].we) checkOutput("load_addr", 32'(la), 32'(vecs[i].addr));
      checkOutput("busy_cycles", 32'(bc), 32'd2);
      @(posedge clk); #1;
      checkOutput("ack_clear", 32'(ack), 32'd0);
      checkOutput("busy_clear", 32'(busy), 32'd0);
    end

    // Reset during ACCESS must abort the write without an ack
    applyStimulus(0, 1'b1, 9'd363, 16'h1111, 16'h1111);
    waitAck(lat, loads, bc, la);
    @(posedge clk); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'd363; wdata0 = 16'h9999;
    @(posedge clk); #1;
    checkOutput("abort_busy", 32'(busy), 32'd1);
    checkOutput("abort_load_pre", 32'(ram_load), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_load_masked", 32'(ram_load), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; req0 = 1'b0; we0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("abort_no_ack", 32'(ack), 32'd0);
      @(posedge clk); #1;
    end
    applyStimulus(1, 1'b0, 9'd363, 16'h0000, 16'h1111);
    waitAck(lat, loads, bc, la);
    @(posedge clk); #1;

    // Back-to-back writes then reads from port 0, next request issued in RESP
    prevCyc = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, bbAddr[i], bbData[i], bbData[i]);
      waitAck(lat, loads, bc, la);
      if (i > 0) checkOutput("b2b_wr_gap", 32'(cycleCount - prevCyc), 32'd3);
      prevCyc = cycleCount;
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b0, bbAddr[i], 16'h0000, bbData[i]);
      waitAck(lat, loads, bc, la);
      checkOutput("b2b_rd_gap", 32'(cycleCount - prevCyc), 32'd3);
      prevCyc = cycleCount;
    end
    @(posedge clk); #1;

    // Continuous contention: port 0 writes 511, port 1 reads 511
    doReset();
    for (int k = 0; k < 10; k++) begin
      e.ack   = (FIXED || (k % 2 == 0)) ? 2'b01 : 2'b10;
      e.rdata = 16'h7511;
      e.cyc   = 2 + 3 * k;
      sbQ.push_back(e);
    end
    req0 = 1'b1; we0 = 1'b1; addr0 = 9'd511; wdata0 = 16'h7511;
    req1 = 1'b1; we1 = 1'b0; addr1 = 9'd511; wdata1 = 16'h0000;
    startCyc = cycleCount;
    p0Acks = 0; p1Acks = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (ack[0]) p0Acks++;
      if (ack[1]) p1Acks++;
      if (ack != 2'b00) popAndCheck(cycleCount - startCyc);
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("contend_p0_acks", 32'(p0Acks), FIXED ? 32'd10 : 32'd5);
    checkOutput("contend_p1_acks", 32'(p1Acks), FIXED ? 32'd0 : 32'd5);
    checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
